// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: write-side arbiter for the dual-clock FIFO (wclk domain).
// Shares one FIFO write port among N_REQ requesters using round-robin fairness.
// Grants are combinational, so a word is accepted in the same cycle it is chosen.
// Define FIFO_WR_ARB_BURST_EN to let an owner keep the grant for up to
// BURST_LEN consecutive words. Without it, arbitration is pure per-word round-robin.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       wclk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     din,
    output logic [N_REQ-1:0]           gnt,
    input  logic                       wfull,
    output logic                       winc,
    output logic [WIDTH-1:0]           wdata,
    output logic [$clog2(N_REQ)-1:0]   src_id,
    output logic [CNT_W-1:0]           wr_cnt
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned NR    = N_REQ;

    // Reject out-of-range configurations at elaboration.
    if (N_REQ < 2 || N_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_params
        $error("fifo_wr_arbiter: N_REQ must be 2..8 and BURST_LEN 1..16");
    end

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] sel;
    logic             sel_vld;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic             act;

    // Round-robin pick: first active requester searching upward from last+1.
    always_comb begin
        logic [IDX_W-1:0] cand;
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        for (int unsigned off = 1; off <= NR; off++) begin
            cand = IDX_W'((32'(last) + off) % NR);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int unsigned BCNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [BCNT_W-1:0] bcnt, bcnt_nxt;
    logic [BCNT_W-1:0] bcnt_inc;

    assign bcnt_inc = bcnt + 1'b1;

    // Burst FSM: keep the owner while it requests; a dropped owner falls
    // straight through to a round-robin pick in the same cycle (no bubble).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        state_nxt = state;
        owner_nxt = owner;
        bcnt_nxt  = bcnt;
        if (!wfull) begin
            if (state == BURST && req[owner]) begin
                grant_vld = 1'b1;
                grant_idx = owner;
                bcnt_nxt  = bcnt_inc;
                if (bcnt_inc == BCNT_W'(BURST_LEN)) begin
                    state_nxt = IDLE;
                    bcnt_nxt  = '0;
                end
            end else begin
                state_nxt = IDLE;
                bcnt_nxt  = '0;
                if (sel_vld) begin
                    grant_vld = 1'b1;
                    grant_idx = sel;
                    if (BURST_LEN > 1) begin
                        state_nxt = BURST;
                        owner_nxt = sel;
                        bcnt_nxt  = BCNT_W'(1);
                    end
                end
            end
        end
    end

    // Burst state register; reset abandons any burst in progress.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            bcnt  <= bcnt_nxt;
        end
    end
`else
    // Per-word round-robin: every accepted word re-arbitrates.
    always_comb begin
        grant_vld = !wfull && sel_vld;
        grant_idx = sel;
    end
`endif

    // Outputs are forced idle while reset is asserted.
    assign act    = grant_vld && rst_n;
    assign winc   = act;
    assign src_id = act ? grant_idx : '0;

    // One-hot grant and write-data mux for the chosen requester.
    always_comb begin
        gnt   = '0;
        wdata = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (act && grant_idx == IDX_W'(i)) begin
                gnt[i] = 1'b1;
                wdata  = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pointer and accepted-word counter.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            last   <= IDX_W'(N_REQ - 1);
            wr_cnt <= '0;
        end else if (grant_vld) begin
            last   <= grant_idx;
            wr_cnt <= wr_cnt + 1'b1;
        end
    end

endmodule
